// File: rtl/cp0_exc_ctrl.sv
// MIPS coprocessor-0 exception/interrupt control: SR, Cause, EPC, PRId and interrupt request.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl #(
   parameter int          NUM_HWINT  = 6,
   parameter logic [31:0] PRID_VALUE = 32'h0000_5500,
   parameter int          EPC_ALIGN  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rd_addr,
   output logic [31:0]          rd_data,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [31:0]          wr_data,
   input  logic [NUM_HWINT-1:0] hwint,
   input  logic                 exc_req,
   input  logic [4:0]           exc_code,
   input  logic [31:0]          exc_pc,
   input  logic                 exc_bd,
   input  logic                 eret,
   output logic                 intr,
   output logic [31:0]          epc_out,
   output logic                 exl_out
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam logic [5:0] HW_MASK = 6'((7'd1 << NUM_HWINT) - 7'd1);
`ifdef CP0_TIMER_EN
   // IM[15] must stay writable so the timer interrupt can be unmasked.
   localparam logic [5:0] IM_MASK = HW_MASK | 6'b10_0000;
`else
   localparam logic [5:0] IM_MASK = HW_MASK;
`endif

   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        exl_q, exl_d;
   logic [5:0]  ip_q, ip_d;
   logic        bd_q, bd_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] epc_q, epc_d;
   logic        ti_q;
   logic [5:0]  ip_eff;
   logic [31:0] sr_rd, cause_rd, epc_capture;

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_d;
`else
   assign ti_q = 1'b0;
`endif

   assign epc_capture = (EPC_ALIGN != 0) ? {exc_pc[31:2], 2'b00} : exc_pc;

   always_comb begin
      ip_d   = 6'(hwint);
      im_d   = im_q;
      ie_d   = ie_q;
      exl_d  = exl_q;
      epc_d  = epc_q;
      bd_d   = bd_q;
      code_d = code_q;
`ifdef CP0_TIMER_EN
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      ti_d      = ti_q;
      if ((count_q == compare_q) && (compare_q != 32'd0))
         ti_d = 1'b1;
`endif
      // MTC0 first; eret and exception entry then override in priority order.
      if (wr_en) begin
         case (wr_addr)
            REG_SR: begin
               im_d  = wr_data[15:10] & IM_MASK;
               exl_d = wr_data[1];
               ie_d  = wr_data[0];
            end
            REG_EPC: epc_d = wr_data;
`ifdef CP0_TIMER_EN
            REG_COUNT: count_d = wr_data;
            REG_COMPARE: begin
               compare_d = wr_data;
               ti_d      = 1'b0;
            end
`endif
            default: ;
         endcase
      end
      if (eret)
         exl_d = 1'b0;
      if (exc_req) begin
         code_d = exc_code;
         exl_d  = 1'b1;
         if (!exl_q) begin
            epc_d = epc_capture;
            bd_d  = exc_bd;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q   <= '0;
         ie_q   <= 1'b0;
         exl_q  <= 1'b0;
         ip_q   <= '0;
         bd_q   <= 1'b0;
         code_q <= '0;
         epc_q  <= '0;
      end else begin
         im_q   <= im_d;
         ie_q   <= ie_d;
         exl_q  <= exl_d;
         ip_q   <= ip_d;
         bd_q   <= bd_d;
         code_q <= code_d;
         epc_q  <= epc_d;
      end
   end

`ifdef CP0_TIMER_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end
`endif

   assign ip_eff   = {ip_q[5] | ti_q, ip_q[4:0]};
   assign sr_rd    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
   assign cause_rd = {bd_q, ti_q, 14'h0000, ip_eff, 3'b000, code_q, 2'b00};

   always_comb begin
      rd_data = 32'h0000_0000;
      case (rd_addr)
         REG_SR:    rd_data = sr_rd;
         REG_CAUSE: rd_data = cause_rd;
         REG_EPC:   rd_data = epc_q;
         REG_PRID:  rd_data = PRID_VALUE;
`ifdef CP0_TIMER_EN
         REG_COUNT:   rd_data = count_q;
         REG_COMPARE: rd_data = compare_q;
`endif
         default: ;
      endcase
   end

   assign intr    = (|(ip_eff & im_q)) & ie_q & ~exl_q;
   assign epc_out = epc_q;
   assign exl_out = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed testbench for cp0_exc_ctrl: reset, masked interrupts, exception entry, nesting, collisions.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [5:0]  hwint = '0;
   logic        exc_req = 1'b0;
   logic [4:0]  exc_code = '0;
   logic [31:0] exc_pc = '0;
   logic        exc_bd = 1'b0;
   logic        eret = 1'b0;
   logic        intr;
   logic [31:0] epc_out;
   logic        exl_out;

   int checks = 0;
   int failures = 0;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hwint(hwint),
      .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .eret(eret), .intr(intr), .epc_out(epc_out), .exl_out(exl_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      rd_addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      #12;
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL rst_intr: got %b expected 0", intr); end
      checks++; if (exl_out !== 1'b0) begin failures++; $display("FAIL rst_exl: got %b expected 0", exl_out); end
      checks++; if (epc_out !== 32'h0) begin failures++; $display("FAIL rst_epc: got %08h expected 0", epc_out); end
      rd(5'd12, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_sr: got %08h expected 0", v); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      mtc0(5'd14, 32'h1234_5678);
      mtc0(5'd12, 32'h0000_FC01);
      hwint = 6'h3F;
      step();
      rd(5'd12, v);
      checks++; if (v !== 32'h0000_FC01) begin failures++; $display("FAIL t1_sr_pre: got %08h expected 0000fc01", v); end
      checks++; if (epc_out !== 32'h1234_5678) begin failures++; $display("FAIL t1_epc_pre: got %08h expected 12345678", epc_out); end
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL t1_intr_pre: got %b expected 1", intr); end
      reset = 1'b1;
      #1;
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t1_intr_async: got %b expected 0", intr); end
      checks++; if (epc_out !== 32'h0) begin failures++; $display("FAIL t1_epc_async: got %08h expected 0", epc_out); end
      rd(5'd12, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL t1_sr_async: got %08h expected 0", v); end
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL t1_cause_async: got %08h expected 0", v); end
      hwint = 6'h00;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_masked_irq();
      logic [31:0] v;
      mtc0(5'd12, 32'h0000_0401);
      hwint = 6'b000001;
      #1;
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t2_latency: got %b expected 0", intr); end
      step();
      rd(5'd13, v);
      chk32("t2_cause", v, 32'h0000_0400);
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL t2_intr: got %b expected 1", intr); end
      mtc0(5'd12, 32'h0000_0001);
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t2_im0_intr: got %b expected 0", intr); end
      rd(5'd12, v);
      chk32("t2_sr_im0", v, 32'h0000_0001);
      mtc0(5'd12, 32'hFFFF_FFFC);
      rd(5'd12, v);
      chk32("t2_sr_bits", v, 32'h0000_FC00);
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t2_ie0_intr: got %b expected 0", intr); end
      mtc0(5'd12, 32'h0000_0401);
   endtask

   task automatic test_entry();
      logic [31:0] v;
      exc_req = 1'b1; exc_code = 5'd0; exc_pc = 32'h0040_0103; exc_bd = 1'b1;
      step();
      exc_req = 1'b0;
      chk32("t3_epc", epc_out, 32'h0040_0100);
      rd(5'd13, v);
      chk32("t3_cause", v, 32'h8000_0400);
      checks++; if (exl_out !== 1'b1) begin failures++; $display("FAIL t3_exl: got %b expected 1", exl_out); end
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t3_intr: got %b expected 0", intr); end
      rd(5'd12, v);
      chk32("t3_sr", v, 32'h0000_0403);
   endtask

   task automatic test_nested();
      logic [31:0] v;
      exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h0000_1000; exc_bd = 1'b0;
      step();
      exc_req = 1'b0;
      chk32("t4_epc_hold", epc_out, 32'h0040_0100);
      rd(5'd13, v);
      chk32("t4_cause", v, 32'h8000_0428);
      checks++; if (exl_out !== 1'b1) begin failures++; $display("FAIL t4_exl: got %b expected 1", exl_out); end
      eret = 1'b1;
      step();
      eret = 1'b0;
      checks++; if (exl_out !== 1'b0) begin failures++; $display("FAIL t4_eret_exl: got %b expected 0", exl_out); end
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL t4_eret_intr: got %b expected 1", intr); end
      chk32("t4_eret_epc", epc_out, 32'h0040_0100);
   endtask

   task automatic test_collisions();
      logic [31:0] v;
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0001;
      exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_2000; exc_bd = 1'b0;
      rd(5'd12, v);
      chk32("t5_rdw_old", v, 32'h0000_0401);
      step();
      wr_en = 1'b0; exc_req = 1'b0;
      rd(5'd12, v);
      chk32("t5_sr_exc", v, 32'h0000_0003);
      chk32("t5_epc", epc_out, 32'h0000_2000);
      rd(5'd13, v);
      chk32("t5_cause", v, 32'h0000_0410);
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t5_intr: got %b expected 0", intr); end
      eret = 1'b1; step(); eret = 1'b0;
      checks++; if (exl_out !== 1'b0) begin failures++; $display("FAIL t5_eret: got %b expected 0", exl_out); end
      exc_req = 1'b1; eret = 1'b1; exc_pc = 32'h0000_2100;
      step();
      exc_req = 1'b0; eret = 1'b0;
      checks++; if (exl_out !== 1'b1) begin failures++; $display("FAIL t5_exc_eret: got %b expected 1", exl_out); end
      chk32("t5_exc_eret_epc", epc_out, 32'h0000_2100);
      eret = 1'b1; step(); eret = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
      exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_3004;
      step();
      wr_en = 1'b0; exc_req = 1'b0;
      chk32("t5_epc_collide", epc_out, 32'h0000_3004);
      mtc0(5'd14, 32'h0000_5000);
      chk32("t5_epc_mtc0", epc_out, 32'h0000_5000);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, v);
      chk32("t5_cause_ro", v, 32'h0000_0420);
      mtc0(5'd15, 32'h0000_0000);
      rd(5'd15, v);
      chk32("t5_prid", v, 32'h0000_5500);
      mtc0(5'd3, 32'hFFFF_FFFF);
      rd(5'd3, v);
      chk32("t5_unmapped", v, 32'h0000_0000);
      eret = 1'b1; step(); eret = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      hwint = 6'b100000;
      step();
      rd(5'd13, v);
      chk32("b2b_ip15", v, 32'h0000_8020);
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL b2b_masked: got %b expected 0", intr); end
      hwint = 6'b000000;
      step();
      rd(5'd13, v);
      chk32("b2b_ip_clear", v, 32'h0000_0020);
      mtc0(5'd12, 32'h0000_0401);
      hwint = 6'b000001;
      step();
      hwint = 6'b000000;
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL b2b_intr_on: got %b expected 1", intr); end
      step();
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL b2b_not_sticky: got %b expected 0", intr); end
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      logic [31:0] v;
      int n;
      mtc0(5'd11, 32'd20);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      n = 0;
      while (intr !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL t6_intr_timeout: got %b expected 1", intr); end
      rd(5'd9, v);
      chk32("t6_count", v, 32'd21);
      rd(5'd13, v);
      checks++; if (v[30] !== 1'b1) begin failures++; $display("FAIL t6_ti: got %b expected 1", v[30]); end
      mtc0(5'd11, 32'd50);
      rd(5'd13, v);
      checks++; if (v[30] !== 1'b0) begin failures++; $display("FAIL t6_ti_clear: got %b expected 0", v[30]); end
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL t6_intr_clear: got %b expected 0", intr); end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid();
      test_masked_irq();
      test_entry();
      test_nested();
      test_collisions();
      test_back_to_back();
`ifdef CP0_TIMER_EN
      test_timer();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
